// File: rtl/dsp_slice_mac_pipe_if.sv
// Handshake and data bundle for dsp_slice_mac_pipe.
// The master side feeds beats and accepts results. The slave side is the slice.
interface dsp_slice_mac_pipe_if #(
    parameter int DWIDTH = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        mode;
    logic [DWIDTH-1:0] a_in;
    logic [DWIDTH-1:0] b_in;
    logic              carry_in;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] c_out;
    logic              carry_out;
    logic              overflow;
    logic              busy;

    modport master (
        output in_valid, mode, a_in, b_in, carry_in, out_ready,
        input  in_ready, out_valid, c_out, carry_out, overflow, busy
    );

    modport slave (
        input  in_valid, mode, a_in, b_in, carry_in, out_ready,
        output in_ready, out_valid, c_out, carry_out, overflow, busy
    );
endinterface

// File: rtl/dsp_slice_mac_pipe.sv
// Two-stage pipelined DSP slice: add, saturating multiply, and saturating
// multiply-accumulate over bursts of ACC_LEN beats.
// Optional feature macro: DSP_SLICE_CASCADE_EN adds cascade_in (accumulator
// seed taken on the first MAC beat) and cascade_out (registered accumulator).
//
// state    | meaning
// ST_IDLE  | no burst open; a mode=10 beat opens one
// ST_ACCUM | burst open; every accepted beat is a MAC beat until the last
module dsp_slice_mac_pipe #(
    parameter int DWIDTH    = 8,
    parameter int ACC_WIDTH = 20,
    parameter int ACC_LEN   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    dsp_slice_mac_pipe_if.slave  bus
`ifdef DSP_SLICE_CASCADE_EN
    ,
    input  logic [ACC_WIDTH-1:0] cascade_in,
    output logic [ACC_WIDTH-1:0] cascade_out
`endif
);

    localparam int CNT_W = $clog2(ACC_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(ACC_LEN);

    typedef enum logic { ST_IDLE, ST_ACCUM } state_t;
    typedef enum logic [1:0] { OP_ADD, OP_MUL, OP_MAC } op_t;

    // Returns {clipped, value} of x saturated to signed DWIDTH.
    function automatic logic [DWIDTH:0] sat_dw(input logic signed [ACC_WIDTH-1:0] x);
        logic [ACC_WIDTH-DWIDTH:0] top;
        top = x[ACC_WIDTH-1:DWIDTH-1];
        if ((&top) || !(|top)) return {1'b0, x[DWIDTH-1:0]};
        return {1'b1, x[ACC_WIDTH-1], {(DWIDTH-1){~x[ACC_WIDTH-1]}}};
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   s1_valid_q, s1_valid_d;
    op_t                    s1_op_q, s1_op_d;
    logic [DWIDTH-1:0]      s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic                   s1_ci_q, s1_ci_d;
    logic                   s1_first_q, s1_first_d, s1_last_q, s1_last_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                   sticky_q, sticky_d;
    logic                   out_valid_q, out_valid_d;
    logic [DWIDTH-1:0]      c_out_q, c_out_d;
    logic                   carry_out_q, carry_out_d;
    logic                   overflow_q, overflow_d;

    logic                   en, accept;
    logic signed [ACC_WIDTH-1:0] seed;
    logic signed [2*DWIDTH-1:0]  prod;
    logic signed [ACC_WIDTH-1:0] prod_ext, base, acc_new;
    logic signed [ACC_WIDTH:0]   acc_sum;
    logic                   acc_clip;
    logic [DWIDTH:0]        add_sum, mul_sat, fin_sat;

`ifdef DSP_SLICE_CASCADE_EN
    logic signed [ACC_WIDTH-1:0] s1_seed_q, s1_seed_d, cascade_out_q, cascade_out_d;
    assign seed        = s1_seed_q;
    assign cascade_out = cascade_out_q;
`else
    assign seed = '0;
`endif

    // Whole pipeline advances only when the output slot is free or draining.
    assign en     = !out_valid_q || bus.out_ready;
    assign accept = bus.in_valid && en;

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.c_out     = c_out_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = (state_q == ST_ACCUM);

    // S2 arithmetic, all taken from the S1 registers.
    assign prod     = (2*DWIDTH)'($signed(s1_a_q)) * (2*DWIDTH)'($signed(s1_b_q));
    assign prod_ext = ACC_WIDTH'(prod);
    assign base     = s1_first_q ? seed : acc_q;
    assign acc_sum  = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(prod_ext);
    assign acc_clip = acc_sum[ACC_WIDTH] ^ acc_sum[ACC_WIDTH-1];
    assign acc_new  = acc_clip ? {acc_sum[ACC_WIDTH], {(ACC_WIDTH-1){~acc_sum[ACC_WIDTH]}}}
                               : acc_sum[ACC_WIDTH-1:0];
    assign add_sum  = {1'b0, s1_a_q} + {1'b0, s1_b_q} + (DWIDTH+1)'(s1_ci_q);
    assign mul_sat  = sat_dw(prod_ext);
    assign fin_sat  = sat_dw(acc_new);

    // Next-state for burst tracking, the S1 capture and the S2 result.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cnt_inc     = cnt_q + CNT_W'(1);
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_ci_d     = s1_ci_q;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        c_out_d     = c_out_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
`ifdef DSP_SLICE_CASCADE_EN
        s1_seed_d     = s1_seed_q;
        cascade_out_d = cascade_out_q;
`endif

        if (en) s1_valid_d = bus.in_valid;

        if (accept) begin
            s1_a_d     = bus.a_in;
            s1_b_d     = bus.b_in;
            s1_ci_d    = bus.carry_in;
            s1_first_d = 1'b0;
            s1_last_d  = 1'b0;
            if (state_q == ST_ACCUM) begin
                s1_op_d = OP_MAC;
                if (cnt_inc == LEN_C) begin
                    s1_last_d = 1'b1;
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else if (bus.mode == 2'b10) begin
                s1_op_d    = OP_MAC;
                s1_first_d = 1'b1;
`ifdef DSP_SLICE_CASCADE_EN
                s1_seed_d  = cascade_in;
`endif
                if (LEN_C == CNT_W'(1)) begin
                    s1_last_d = 1'b1;
                end else begin
                    state_d = ST_ACCUM;
                    cnt_d   = CNT_W'(1);
                end
            end else if (bus.mode == 2'b01) begin
                s1_op_d = OP_MUL;
            end else begin
                s1_op_d = OP_ADD;
            end
        end

        if (en) begin
            out_valid_d = 1'b0;
            if (s1_valid_q) begin
                case (s1_op_q)
                    OP_MUL: begin
                        out_valid_d = 1'b1;
                        c_out_d     = mul_sat[DWIDTH-1:0];
                        carry_out_d = 1'b0;
                        overflow_d  = mul_sat[DWIDTH];
                    end
                    OP_MAC: begin
                        acc_d    = acc_new;
                        sticky_d = (sticky_q && !s1_first_q) || acc_clip;
                        if (s1_last_q) begin
                            out_valid_d = 1'b1;
                            c_out_d     = fin_sat[DWIDTH-1:0];
                            carry_out_d = 1'b0;
                            overflow_d  = sticky_d || fin_sat[DWIDTH];
`ifdef DSP_SLICE_CASCADE_EN
                            cascade_out_d = acc_new;
`endif
                        end
                    end
                    default: begin
                        out_valid_d = 1'b1;
                        c_out_d     = add_sum[DWIDTH-1:0];
                        carry_out_d = add_sum[DWIDTH];
                        overflow_d  = 1'b0;
                    end
                endcase
            end
        end
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_ADD;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_ci_q     <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            c_out_q     <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef DSP_SLICE_CASCADE_EN
            s1_seed_q     <= '0;
            cascade_out_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_ci_q     <= s1_ci_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            c_out_q     <= c_out_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
`ifdef DSP_SLICE_CASCADE_EN
            s1_seed_q     <= s1_seed_d;
            cascade_out_q <= cascade_out_d;
`endif
        end
    end

endmodule

// File: tb/tb_dsp_slice_mac_pipe.sv
// Self-checking bench for dsp_slice_mac_pipe (DWIDTH=8, ACC_WIDTH=20, ACC_LEN=4).
// Expected results come from an integer-arithmetic reference model fed at
// every accepted beat and compared in order at every accepted result.
module tb_dsp_slice_mac_pipe;
    localparam int DW = 8;
    localparam int AW = 20;
    localparam int AL = 4;
    localparam int ACC_MAX = (1 << (AW - 1)) - 1;
    localparam int ACC_MIN = -(1 << (AW - 1));

    typedef struct packed {
        logic [7:0] c;
        logic       co;
        logic       ovf;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dsp_slice_mac_pipe_if #(.DWIDTH(DW)) bus ();

`ifdef DSP_SLICE_CASCADE_EN
    logic [AW-1:0] cascade_in = '0;
    logic [AW-1:0] cascade_out;
`endif

    dsp_slice_mac_pipe #(.DWIDTH(DW), .ACC_WIDTH(AW), .ACC_LEN(AL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DSP_SLICE_CASCADE_EN
        ,
        .cascade_in  (cascade_in),
        .cascade_out (cascade_out)
`endif
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t exp_q[$];
    bit   m_busy   = 0;
    int   m_n      = 0;
    int   m_acc    = 0;
    bit   m_sticky = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int sat(int v, int lo, int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_busy = 0; m_n = 0; m_acc = 0; m_sticky = 0;
    endtask

    // Reference behaviour of one accepted beat.
    task automatic model_beat(logic [1:0] m, logic [7:0] a, logic [7:0] b, logic ci);
        int p, s, f, clipped;
        res_t r;
        p = int'($signed(a)) * int'($signed(b));
        if (m_busy || m == 2'b10) begin
            if (!m_busy) begin
                m_busy = 1; m_n = 0; m_sticky = 0;
`ifdef DSP_SLICE_CASCADE_EN
                m_acc = int'($signed(cascade_in));
`else
                m_acc = 0;
`endif
            end
            clipped = sat(m_acc + p, ACC_MIN, ACC_MAX);
            if (clipped != m_acc + p) m_sticky = 1;
            m_acc = clipped;
            m_n++;
            if (m_n == AL) begin
                f = sat(m_acc, -128, 127);
                r.c = f[7:0]; r.co = 1'b0; r.ovf = m_sticky || (f != m_acc);
                exp_q.push_back(r);
                m_busy = 0;
            end
        end else if (m == 2'b01) begin
            f = sat(p, -128, 127);
            r.c = f[7:0]; r.co = 1'b0; r.ovf = (f != p);
            exp_q.push_back(r);
        end else begin
            s = int'(a) + int'(b) + int'(ci);
            r.c = s[7:0]; r.co = s[8]; r.ovf = 1'b0;
            exp_q.push_back(r);
        end
    endtask

    // One clock: record handshakes before the edge, then step past it.
    task automatic tick(output bit accepted);
        bit in_hs, out_hs;
        res_t e;
        #1;
        in_hs    = bus.in_valid && bus.in_ready;
        out_hs   = bus.out_valid && bus.out_ready;
        accepted = in_hs && reset;
        if (!reset) begin
            model_clear();
        end else begin
            if (out_hs) begin
                check("result_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("res_c_out", bus.c_out, e.c);
                    check("res_carry_out", bus.carry_out, e.co);
                    check("res_overflow", bus.overflow, e.ovf);
                end
            end
            if (in_hs) model_beat(bus.mode, bus.a_in, bus.b_in, bus.carry_in);
        end
        @(posedge clk);
        #1;
        if (reset) check("busy", bus.busy, m_busy);
    endtask

    task automatic drive(logic v, logic [1:0] m, logic [7:0] a, logic [7:0] b, logic ci);
        bus.in_valid = v; bus.mode = m; bus.a_in = a; bus.b_in = b; bus.carry_in = ci;
    endtask

    task automatic send(logic [1:0] m, logic [7:0] a, logic [7:0] b, logic ci);
        bit acc = 0;
        int k = 0;
        drive(1'b1, m, a, b, ci);
        while (!acc && k < 50) begin
            tick(acc);
            k++;
        end
        check("beat_accepted", 32'(acc), 1);
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic wait_result(string tag, logic [7:0] ec, logic eco, logic eovf);
        bit acc;
        int k = 0;
        while (bus.out_valid !== 1'b1 && k < 20) begin
            tick(acc);
            k++;
        end
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_c_out"}, bus.c_out, ec);
        check({tag, "_carry"}, bus.carry_out, eco);
        check({tag, "_ovf"}, bus.overflow, eovf);
    endtask

    task automatic drain(string tag);
        bit acc;
        int k = 0;
        bus.out_ready = 1'b1;
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        while (exp_q.size() > 0 && k < 50) begin
            tick(acc);
            k++;
        end
        tick(acc);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_idle"}, bus.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   acc;
        res_t held;
        int   k;

        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        bus.out_ready = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_c_out", bus.c_out, 0);
        check("rst_carry", bus.carry_out, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        reset = 1'b1;

        // Add, with exact two-cycle latency.
        send(2'b00, 8'hF0, 8'h20, 1'b1);
        check("add_lat_early", bus.out_valid, 0);
        tick(acc);
        check("add_lat_valid", bus.out_valid, 1);
        check("add_c_out", bus.c_out, 8'h11);
        check("add_carry", bus.carry_out, 1);
        check("add_ovf", bus.overflow, 0);
        drain("add");

        // Multiply corner cases.
        send(2'b01, 8'h80, 8'h80, 1'b0);
        wait_result("mul_negneg", 8'h7F, 1'b0, 1'b1);
        send(2'b01, 8'h03, 8'hFB, 1'b1);
        wait_result("mul_small", 8'hF1, 1'b0, 1'b0);
        send(2'b01, 8'h80, 8'h7F, 1'b0);
        wait_result("mul_negpos", 8'h80, 1'b0, 1'b1);
        drain("mul");

        // MAC burst with gaps; the mode of later beats must not matter.
        send(2'b10, 8'd2, 8'd3, 1'b0);
        tick(acc);
        send(2'b01, 8'd4, 8'd5, 1'b0);
        tick(acc);
        send(2'b00, 8'hFF, 8'd6, 1'b1);
        tick(acc);
        check("mac_busy_mid", bus.busy, 1);
        send(2'b11, 8'd7, 8'd1, 1'b0);
        check("mac_busy_end", bus.busy, 0);
        wait_result("mac", 8'h1B, 1'b0, 1'b0);
        drain("mac");

        // Reset in the middle of a burst drops the partial sum.
        send(2'b10, 8'd20, 8'd20, 1'b0);
        send(2'b10, 8'd30, 8'd30, 1'b0);
        reset = 1'b0;
        tick(acc);
        tick(acc);
        check("rst_mid_out_valid", bus.out_valid, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_ovf", bus.overflow, 0);
        reset = 1'b1;
        for (int i = 0; i < AL; i++) send(2'b10, 8'd1, 8'd1, 1'b0);
        wait_result("rst_mid_new_burst", 8'd4, 1'b0, 1'b0);
        drain("rst_mid");

        // Backpressure: output held, input stalled, no result lost.
        bus.out_ready = 1'b0;
        send(2'b01, 8'($urandom), 8'($urandom), 1'b0);
        send(2'b01, 8'($urandom), 8'($urandom), 1'b0);
        drive(1'b1, 2'b01, 8'($urandom), 8'($urandom), 1'b0);
        held = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            check("bp_valid", bus.out_valid, 1);
            check("bp_c_out_stable", bus.c_out, held.c);
            check("bp_ovf_stable", bus.overflow, held.ovf);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_no_accept", 32'(acc), 0);
        end
        bus.out_ready = 1'b1;
        acc = 0;
        k = 0;
        while (!acc && k < 20) begin
            tick(acc);
            k++;
        end
        check("bp_third_accepted", 32'(acc), 1);
        drain("bp");

        // Saturating MAC (optionally seeded through the cascade input).
`ifdef DSP_SLICE_CASCADE_EN
        cascade_in = AW'(-64000);
`endif
        for (int i = 0; i < AL; i++) send(2'b10, 8'h7F, 8'h7F, 1'b0);
        wait_result("mac_ovf", 8'h7F, 1'b0, 1'b1);
`ifdef DSP_SLICE_CASCADE_EN
        check("cascade_out", cascade_out, AW'(516));
        cascade_in = '0;
`endif
        drain("mac_ovf");

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  8'($urandom), 8'($urandom), 1'($urandom));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
        end
        bus.out_ready = 1'b1;
        k = 0;
        while (m_busy && k < 50) begin
            drive(1'b1, 2'b10, 8'($urandom), 8'($urandom), 1'b0);
            tick(acc);
            k++;
        end
        check("rand_burst_closed", 32'(m_busy), 0);
        drain("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
